dmem_port_arbiter: RTL

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory, with an
// exclusive-lock mode for port 1 and a tag pipeline that routes read data back.
module dmem_port_arbiter #(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_q,

    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_q,

    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] LOCK1 = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                r_last;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_push_vld;
    logic                w_push_tag;
    logic [READ_LAT-1:0] r_pipe_vld;
    logic [READ_LAT-1:0] r_pipe_tag;
    logic [READ_LAT:0]   w_vld_ext;
    logic [READ_LAT:0]   w_tag_ext;
    logic                w_ret_vld;
    logic                w_ret_tag;

    // Grants are gated by reset so nothing reaches dmem while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset) begin
            case (r_state)
                LOCK1: w_gnt1 = p1_req;
                default: begin
                    if (p0_req && p1_req) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = p0_req;
                        w_gnt1 = p1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_gnt1 && p1_lock) w_state_nxt = LOCK1;
            LOCK1:   if (!p1_lock) w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ARB;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
        end
    end

    always_comb begin
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        if (w_gnt0) begin
            address_dmem = p0_address;
            data         = p0_data;
            wren         = p0_wren;
        end else if (w_gnt1) begin
            address_dmem = p1_address;
            data         = p1_data;
            wren         = p1_wren;
        end
    end

    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;

    // One entry enters per cycle; only granted reads carry valid=1.
    assign w_push_vld = (w_gnt0 | w_gnt1) & ~wren;
    assign w_push_tag = w_gnt1;
    assign w_vld_ext  = {r_pipe_vld, w_push_vld};
    assign w_tag_ext  = {r_pipe_tag, w_push_tag};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pipe_vld <= '0;
            r_pipe_tag <= '0;
        end else begin
            r_pipe_vld <= w_vld_ext[READ_LAT-1:0];
            r_pipe_tag <= w_tag_ext[READ_LAT-1:0];
        end
    end

    assign w_ret_vld = reset & r_pipe_vld[READ_LAT-1];
    assign w_ret_tag = r_pipe_tag[READ_LAT-1];

    assign p0_rvalid = w_ret_vld & ~w_ret_tag;
    assign p1_rvalid = w_ret_vld & w_ret_tag;
    assign p0_q      = p0_rvalid ? q_dmem : '0;
    assign p1_q      = p1_rvalid ? q_dmem : '0;

endmodule
